ace_snoop_broadcaster: RTL and testbench

- Multi-cache successor to the single-cache snoop stimulus path of the dcache ACE bench.
- Takes one upstream snoop request and broadcasts it on the AC channel to every cache port except the initiator.
- Collects and merges CR responses, then forwards CD line data from one responder and drains any redundant data.
- Sits between the coherence interconnect model and NumPorts std_nbdcache snoop ports. Used in multi-core bench and CCU prototypes.

---
 rtl/ace_snoop_broadcaster.sv | 173 +++++++++++++++++
 tb/tb_ace_snoop_broadcaster.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ace_snoop_broadcaster.sv
// Broadcasts one upstream snoop to all cache ports except the initiator, merges the CR
// responses, then forwards CD data from one responder while draining the redundant ones.
module ace_snoop_broadcaster #(
   parameter int NumPorts  = 4,
   parameter int AddrWidth = 64,
   parameter int DataWidth = 64,
   parameter int IdxWidth  = (NumPorts > 1) ? $clog2(NumPorts) : 1
) (
   input  logic                          clk_i,
   input  logic                          rst_i,
   input  logic                          snp_valid_i,
   output logic                          snp_ready_o,
   input  logic [AddrWidth-1:0]          snp_addr_i,
   input  logic [3:0]                    snp_snoop_i,
   input  logic [2:0]                    snp_prot_i,
   input  logic [IdxWidth-1:0]           snp_initiator_i,
   output logic                          resp_valid_o,
   input  logic                          resp_ready_i,
   output logic [4:0]                    resp_o,
   output logic                          data_valid_o,
   input  logic                          data_ready_i,
   output logic [DataWidth-1:0]          data_o,
   output logic                          data_last_o,
   output logic [NumPorts-1:0]           ac_valid_o,
   input  logic [NumPorts-1:0]           ac_ready_i,
   output logic [AddrWidth-1:0]          ac_addr_o,
   output logic [3:0]                    ac_snoop_o,
   output logic [2:0]                    ac_prot_o,
   input  logic [NumPorts-1:0]           cr_valid_i,
   output logic [NumPorts-1:0]           cr_ready_o,
   input  logic [5*NumPorts-1:0]         cr_resp_i,
   input  logic [NumPorts-1:0]           cd_valid_i,
   output logic [NumPorts-1:0]           cd_ready_o,
   input  logic [DataWidth*NumPorts-1:0] cd_data_i,
   input  logic [NumPorts-1:0]           cd_last_i
);

   typedef enum logic [1:0] {IDLE, COLLECT, RESP, DATA} state_e;

   state_e                state_q, state_d;
   logic [NumPorts-1:0]   ac_pend_q, ac_pend_d;
   logic [NumPorts-1:0]   cr_pend_q, cr_pend_d;
   logic [NumPorts-1:0]   dt_mask_q, dt_mask_d;
   logic [3:0]            acc_q, acc_d;
   logic [IdxWidth-1:0]   sel_q, sel_d;
   logic                  sel_vld_q, sel_vld_d;
   logic [AddrWidth-1:0]  addr_q, addr_d;
   logic [3:0]            snoop_q, snoop_d;
   logic [2:0]            prot_q, prot_d;
   logic [NumPorts-1:0]   target;
   logic [NumPorts-1:0]   cr_rdy;
   logic [NumPorts-1:0]   cd_rdy;

   // An out-of-range initiator matches no port, so every port is snooped.
   always_comb begin
      target = '1;
      for (int i = 0; i < NumPorts; i++) begin
         if (snp_initiator_i == IdxWidth'(i)) target[i] = 1'b0;
      end
   end

   assign ac_addr_o  = addr_q;
   assign ac_snoop_o = snoop_q;
   assign ac_prot_o  = prot_q;
   assign cr_ready_o = cr_rdy;
   assign cd_ready_o = cd_rdy;

   always_comb begin
      state_d      = state_q;
      ac_pend_d    = ac_pend_q;
      cr_pend_d    = cr_pend_q;
      dt_mask_d    = dt_mask_q;
      acc_d        = acc_q;
      sel_d        = sel_q;
      sel_vld_d    = sel_vld_q;
      addr_d       = addr_q;
      snoop_d      = snoop_q;
      prot_d       = prot_q;
      snp_ready_o  = 1'b0;
      resp_valid_o = 1'b0;
      resp_o       = '0;
      data_valid_o = 1'b0;
      data_o       = '0;
      data_last_o  = 1'b0;
      ac_valid_o   = '0;
      cr_rdy       = '0;
      cd_rdy       = '0;
      case (state_q)
         IDLE: begin
            snp_ready_o = !rst_i;
            if (snp_valid_i) begin
               addr_d    = snp_addr_i;
               snoop_d   = snp_snoop_i;
               prot_d    = snp_prot_i;
               ac_pend_d = target;
               cr_pend_d = target;
               acc_d     = '0;
               dt_mask_d = '0;
               sel_d     = '0;
               sel_vld_d = 1'b0;
               state_d   = COLLECT;
            end
         end
         COLLECT: begin
            ac_valid_o = ac_pend_q;
            ac_pend_d  = ac_pend_q & ~ac_ready_i;
            // A port's CR is only taken once its AC has already been accepted.
            cr_rdy     = cr_pend_q & ~ac_pend_q;
            for (int i = 0; i < NumPorts; i++) begin
               if (cr_rdy[i] && cr_valid_i[i]) begin
                  acc_d        = acc_d | cr_resp_i[5*i+1 +: 4];
                  cr_pend_d[i] = 1'b0;
                  if (cr_resp_i[5*i]) begin
                     dt_mask_d[i] = 1'b1;
                     if (!sel_vld_d) begin
                        sel_vld_d = 1'b1;
                        sel_d     = IdxWidth'(i);
                     end
                  end
               end
            end
            if (cr_pend_d == '0) state_d = RESP;
         end
         RESP: begin
            resp_valid_o = 1'b1;
            resp_o       = {acc_q, |dt_mask_q};
            if (resp_ready_i) state_d = (|dt_mask_q) ? DATA : IDLE;
         end
         DATA: begin
            for (int i = 0; i < NumPorts; i++) begin
               if (sel_q == IdxWidth'(i)) begin
                  data_valid_o = cd_valid_i[i] & dt_mask_q[i];
                  data_o       = cd_data_i[i*DataWidth +: DataWidth];
                  data_last_o  = cd_last_i[i];
               end
               if (dt_mask_q[i]) begin
                  cd_rdy[i] = (sel_q == IdxWidth'(i)) ? data_ready_i : 1'b1;
                  if (cd_rdy[i] && cd_valid_i[i] && cd_last_i[i]) dt_mask_d[i] = 1'b0;
               end
            end
            if (dt_mask_d == '0) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q   <= IDLE;
         ac_pend_q <= '0;
         cr_pend_q <= '0;
         dt_mask_q <= '0;
         acc_q     <= '0;
         sel_q     <= '0;
         sel_vld_q <= 1'b0;
         addr_q    <= '0;
         snoop_q   <= '0;
         prot_q    <= '0;
      end else begin
         state_q   <= state_d;
         ac_pend_q <= ac_pend_d;
         cr_pend_q <= cr_pend_d;
         dt_mask_q <= dt_mask_d;
         acc_q     <= acc_d;
         sel_q     <= sel_d;
         sel_vld_q <= sel_vld_d;
         addr_q    <= addr_d;
         snoop_q   <= snoop_d;
         prot_q    <= prot_d;
      end
   end

endmodule

// File: tb/tb_ace_snoop_broadcaster.sv
// Directed bench for ace_snoop_broadcaster: a 4-port instance driven from a vector table
// through a simple per-port cache model, plus a 1-port instance and a mid-transfer reset.
module tb_ace_snoop_broadcaster;
   localparam int NP = 4;
   localparam int AW = 64;
   localparam int DW = 64;
   localparam int IW = 3;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst;
   logic snp_valid, snp_ready;
   logic [AW-1:0] snp_addr;
   logic [3:0] snp_snoop;
   logic [2:0] snp_prot;
   logic [IW-1:0] snp_init;
   logic resp_valid, resp_ready;
   logic [4:0] resp;
   logic data_valid, data_ready, data_last;
   logic [DW-1:0] data;
   logic [NP-1:0] ac_valid, ac_ready, cr_valid, cr_ready, cd_valid, cd_ready, cd_last;
   logic [AW-1:0] ac_addr;
   logic [3:0] ac_snoop;
   logic [2:0] ac_prot;
   logic [5*NP-1:0] cr_resp;
   logic [DW*NP-1:0] cd_data;

   logic s_snp_valid, s_snp_ready, s_resp_valid, s_resp_ready, s_data_valid, s_data_ready, s_data_last;
   logic [AW-1:0] s_snp_addr, s_ac_addr;
   logic [3:0] s_snp_snoop, s_ac_snoop;
   logic [2:0] s_snp_prot, s_ac_prot;
   logic [0:0] s_snp_init, s_ac_valid, s_ac_ready, s_cr_valid, s_cr_ready, s_cd_valid, s_cd_ready, s_cd_last;
   logic [4:0] s_resp, s_cr_resp;
   logic [DW-1:0] s_data, s_cd_data;

   ace_snoop_broadcaster #(.NumPorts(NP), .AddrWidth(AW), .DataWidth(DW), .IdxWidth(IW)) u4 (
      .clk_i(clk), .rst_i(rst),
      .snp_valid_i(snp_valid), .snp_ready_o(snp_ready), .snp_addr_i(snp_addr),
      .snp_snoop_i(snp_snoop), .snp_prot_i(snp_prot), .snp_initiator_i(snp_init),
      .resp_valid_o(resp_valid), .resp_ready_i(resp_ready), .resp_o(resp),
      .data_valid_o(data_valid), .data_ready_i(data_ready), .data_o(data), .data_last_o(data_last),
      .ac_valid_o(ac_valid), .ac_ready_i(ac_ready), .ac_addr_o(ac_addr),
      .ac_snoop_o(ac_snoop), .ac_prot_o(ac_prot),
      .cr_valid_i(cr_valid), .cr_ready_o(cr_ready), .cr_resp_i(cr_resp),
      .cd_valid_i(cd_valid), .cd_ready_o(cd_ready), .cd_data_i(cd_data), .cd_last_i(cd_last)
   );

   ace_snoop_broadcaster #(.NumPorts(1), .AddrWidth(AW), .DataWidth(DW)) u1 (
      .clk_i(clk), .rst_i(rst),
      .snp_valid_i(s_snp_valid), .snp_ready_o(s_snp_ready), .snp_addr_i(s_snp_addr),
      .snp_snoop_i(s_snp_snoop), .snp_prot_i(s_snp_prot), .snp_initiator_i(s_snp_init),
      .resp_valid_o(s_resp_valid), .resp_ready_i(s_resp_ready), .resp_o(s_resp),
      .data_valid_o(s_data_valid), .data_ready_i(s_data_ready), .data_o(s_data), .data_last_o(s_data_last),
      .ac_valid_o(s_ac_valid), .ac_ready_i(s_ac_ready), .ac_addr_o(s_ac_addr),
      .ac_snoop_o(s_ac_snoop), .ac_prot_o(s_ac_prot),
      .cr_valid_i(s_cr_valid), .cr_ready_o(s_cr_ready), .cr_resp_i(s_cr_resp),
      .cd_valid_i(s_cd_valid), .cd_ready_o(s_cd_ready), .cd_data_i(s_cd_data), .cd_last_i(s_cd_last)
   );

   int total = 0;
   int bad = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   typedef struct {
      logic [IW-1:0] init;
      logic [19:0]   cr;         // per-port CR answers, port p at [5p+4:5p]
      int            dly2;       // port 2 holds ac_ready low for this many cycles
      int            rr_k;       // first cycle resp_ready is high
      logic [3:0]    exp_ac;
      logic [4:0]    exp_resp;
      int            exp_rcyc;
      int            exp_src;    // forwarding port, -1 when no data phase
      int            exp_idle;
      int            exp_drain;
   } vec_t;

   vec_t vecs[7];

   task automatic clear_inputs();
      snp_valid = 1'b0; ac_ready = '0; cr_valid = '0; cd_valid = '0; cd_last = '0;
      resp_ready = 1'b0; data_ready = 1'b0;
   endtask

   // Cycle k=0 is the snoop handshake; port p sends two beats 0xA0+16p, 0xA1+16p.
   task automatic run_vec(input vec_t v, input int idx, input bit abort);
      int k, rcyc, idle_k, nd, drained, viol;
      int beats[NP];
      logic [NP-1:0] ac_done, cr_done, ac_first;
      logic [4:0] resp_first, resp_hs;
      logic [DW-1:0] got[2];
      bit done, rsp_seen;
      rcyc = -1; idle_k = -1; nd = 0; drained = 0; viol = 0;
      ac_done = '0; cr_done = '0; ac_first = '0; resp_first = '0; resp_hs = '0;
      got[0] = '0; got[1] = '0; done = 0; rsp_seen = 0;
      for (int p = 0; p < NP; p++) beats[p] = 0;
      @(negedge clk);
      clear_inputs();
      cr_resp = v.cr;
      snp_valid = 1'b1; snp_init = v.init;
      snp_addr = 64'hFEED_0000_0000_0000 | 64'(idx); snp_snoop = 4'b0001; snp_prot = 3'b010;
      #1 check("snp_ready", snp_ready, 1'b1);
      @(negedge clk);
      snp_valid = 1'b0; snp_addr = '1; snp_snoop = '1; snp_prot = '0;
      k = 1;
      while (!done && k < 80) begin
         for (int p = 0; p < NP; p++) begin
            ac_ready[p] = (p == 2) ? (k > v.dly2) : 1'b1;
            cr_valid[p] = ac_done[p] & ~cr_done[p];
            cd_valid[p] = cr_done[p] && v.cr[5*p] && beats[p] < 2;
            cd_data[p*DW +: DW] = 64'(32'hA0 + 16*p + beats[p]);
            cd_last[p] = (beats[p] == 1);
         end
         resp_ready = (k >= v.rr_k);
         data_ready = !abort;
         #1;
         if (k == 1) begin
            ac_first = ac_valid;
            check("ac_addr", ac_addr, 64'hFEED_0000_0000_0000 | 64'(idx));
            check("ac_snoop_prot", {ac_snoop, ac_prot}, {4'b0001, 3'b010});
         end
         if (abort && data_valid) begin
            done = 1;
         end else if (snp_ready) begin
            idle_k = k; done = 1;
         end else begin
            if ((ac_valid & cr_ready) != '0) viol++;
            if (resp_valid && !rsp_seen) begin rsp_seen = 1; rcyc = k; resp_first = resp; end
            if (resp_valid && resp_ready) resp_hs = resp;
            if (data_valid && data_ready) begin
               if (nd < 2) got[nd] = data;
               nd++;
            end
            for (int p = 0; p < NP; p++) begin
               if (ac_valid[p] && ac_ready[p]) ac_done[p] = 1'b1;
               if (cr_valid[p] && cr_ready[p]) cr_done[p] = 1'b1;
               if (cd_valid[p] && cd_ready[p]) begin
                  beats[p]++;
                  if (p != v.exp_src) drained++;
               end
            end
         end
         if (!done || !abort) begin
            @(negedge clk);
            k++;
         end
      end
      if (abort) begin
         check("reached_data", done, 1'b1);
         check("fwd_while_stalled", nd, 0);
      end else begin
         clear_inputs();
         check("finished", done, 1'b1);
         check("ac_mask", ac_first, v.exp_ac);
         check("resp_cycle", rcyc, v.exp_rcyc);
         check("resp_first", resp_first, v.exp_resp);
         check("resp_at_hs", resp_hs, v.exp_resp);
         check("idle_cycle", idle_k, v.exp_idle);
         check("drained", drained, v.exp_drain);
         check("ac_cr_overlap", viol, 0);
         if (v.exp_src < 0) begin
            check("beats_none", nd, 0);
         end else begin
            check("beats_n", nd, 2);
            check("beat0", got[0], 64'(32'hA0 + 16*v.exp_src));
            check("beat1", got[1], 64'(32'hA1 + 16*v.exp_src));
         end
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit");
      $fatal(1);
   end

   initial begin
      int k, rk;
      bit ac_seen;
      vecs[0] = '{3'd1, 20'h0, 0, 0, 4'b1101, 5'b00000, 3, -1, 4, 0};
      vecs[1] = '{3'd1, {5'b01001, 5'b00000, 5'b00000, 5'b01001}, 0, 0, 4'b1101, 5'b01001, 3, 0, 6, 2};
      vecs[2] = '{3'd1, {5'b01001, 5'b00000, 5'b00000, 5'b01001}, 5, 0, 4'b1101, 5'b01001, 8, 0, 11, 2};
      vecs[3] = '{3'd4, {5'b00000, 5'b00101, 5'b00000, 5'b00000}, 0, 0, 4'b1111, 5'b00101, 3, 2, 6, 0};
      vecs[4] = '{3'd0, {5'b00000, 5'b00001, 5'b01001, 5'b00000}, 0, 0, 4'b1110, 5'b01001, 3, 1, 6, 2};
      vecs[5] = '{3'd3, {5'b00000, 5'b00100, 5'b10000, 5'b00010}, 0, 6, 4'b0111, 5'b10110, 3, -1, 7, 0};
      vecs[6] = '{3'd0, {5'b00001, 5'b00001, 5'b00000, 5'b00000}, 5, 0, 4'b1110, 5'b00001, 8, 3, 11, 2};

      rst = 1'b1;
      clear_inputs();
      snp_addr = '0; snp_snoop = '0; snp_prot = '0; snp_init = '0; cr_resp = '0; cd_data = '0;
      s_snp_valid = 1'b0; s_snp_addr = 64'h55; s_snp_snoop = 4'b0001; s_snp_prot = '0; s_snp_init = 1'b0;
      s_resp_ready = 1'b1; s_data_ready = 1'b1; s_ac_ready = 1'b1; s_cr_valid = 1'b0; s_cr_resp = '0;
      s_cd_valid = 1'b0; s_cd_data = '0; s_cd_last = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_snp_ready", snp_ready, 1'b0);
      check("rst_valids", {ac_valid, resp_valid, data_valid}, '0);
      check("rst_readies", {cr_ready, cd_ready}, '0);
      check("rst_fields", {ac_snoop, ac_prot, resp, data_last}, '0);
      check("rst_addr_data", ac_addr | data, '0);
      rst = 1'b0;
      #1 check("post_rst_snp_ready", {snp_ready, s_snp_ready}, 2'b11);

      for (int i = 0; i < 7; i++) run_vec(vecs[i], i, 1'b0);

      // Single port whose only port is the initiator: no AC, response after two cycles.
      @(negedge clk);
      s_snp_valid = 1'b1;
      #1 check("s_snp_ready", s_snp_ready, 1'b1);
      @(negedge clk);
      s_snp_valid = 1'b0;
      ac_seen = 0; rk = -1; k = 1;
      while (rk < 0 && k < 20) begin
         #1;
         if (s_ac_valid != '0) ac_seen = 1;
         if (s_resp_valid) begin
            rk = k;
            check("s_resp", s_resp, 5'b00000);
         end
         @(negedge clk);
         k++;
      end
      check("s_resp_cycle", rk, 2);
      check("s_no_ac", ac_seen, 1'b0);
      #1 check("s_back_idle", s_snp_ready, 1'b1);

      // Reset while the data phase is stalled, then a clean snoop.
      run_vec(vecs[1], 9, 1'b1);
      rst = 1'b1;
      clear_inputs();
      @(negedge clk);
      check("midrst_valids", {ac_valid, resp_valid, data_valid, snp_ready}, '0);
      check("midrst_readies", {cr_ready, cd_ready}, '0);
      rst = 1'b0;
      #1 check("midrst_snp_ready", snp_ready, 1'b1);
      run_vec(vecs[0], 10, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
